// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : opcodes, state encodings and datapath select codes
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that hold a memory request open and are bounded by the wait timer.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_control_mem_wait_timer.sv
// ============================================================================
// mem_wait_timer : counts memory wait cycles and flags the timeout limit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Any cycle that is not a continued wait restarts the count from zero.
  always_comb begin
    count_d = count_en_i ? count_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/multi_cycle_control.sv
// ============================================================================
// multi_cycle_control : multi-cycle MIPS control FSM for a shared ALU/memory
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       Memtowrite,
  output logic       Memtoreg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [2:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       Regwrite,
  output logic       RegDst,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   in_wait;
  logic   timeout;
  logic   stay_wait;

  assign in_wait   = is_wait_state(state_q);
  // mem_ready takes priority over a coincident timeout.
  assign stay_wait = in_wait && !mem_ready && !timeout;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_mem_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (stay_wait),
    .timeout_o  (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    Memtowrite  = 1'b0;
    Memtoreg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUop       = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    Regwrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;
    state       = state_q;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          mem_err = timeout;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          mem_err = timeout;
          state_d = timeout ? S_FETCH : S_MEMRD;
        end
      end
      S_MEMWB: begin
        Memtoreg = 1'b1;
        Regwrite = 1'b1;
      end
      S_MEMWR: begin
        Memtowrite = 1'b1;
        IorD       = 1'b1;
        if (!mem_ready) begin
          mem_err = timeout;
          state_d = timeout ? S_FETCH : S_MEMWR;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        Regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        Regwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Nothing may reach the datapath while reset is held.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      Memtowrite  = 1'b0;
      Memtoreg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      ALUop       = 3'b000;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      Regwrite    = 1'b0;
      RegDst      = 1'b0;
      illegal_op  = 1'b0;
      mem_err     = 1'b0;
      state       = 4'd0;
    end
  end

endmodule

`default_nettype wire
